// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_wb_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_AW_MAX = 5;

  typedef struct packed {
    logic [RF_AW_MAX-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

  function automatic int aw(input bit embedded);
    return embedded ? 4 : 5;
  endfunction

endpackage

// File: rtl/rf_wb_rr_pick.sv
// Round-robin first-two picker over requesters 1..NREQ-1, starting at ptr_i.
// The second pick never shares an address with the first.
module rf_wb_rr_pick #(
  parameter int NREQ = 3,
  parameter int AW   = 5
) (
  input  logic [NREQ-1:0]         cand_i,
  input  logic [NREQ-1:0]         excl_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  input  logic [AW-1:0]           addr_i [NREQ],
  output logic [NREQ-1:0]         gnt_a_o,
  output logic [NREQ-1:0]         gnt_b_o,
  output logic [$clog2(NREQ)-1:0] idx_a_o,
  output logic [$clog2(NREQ)-1:0] idx_b_o
);

  localparam int PW = $clog2(NREQ);

  int          pos;
  logic [PW-1:0] idx;
  logic        found_a, found_b;
  logic [AW-1:0] addr_a;

  always_comb begin
    gnt_a_o = '0;
    gnt_b_o = '0;
    idx_a_o = '0;
    idx_b_o = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    addr_a  = '0;
    pos     = 0;
    idx     = '0;
    for (int k = 0; k < NREQ-1; k++) begin
      pos = int'(ptr_i) + k;
      if (pos > NREQ-1) pos = pos - (NREQ-1);
      idx = PW'(pos);
      if (cand_i[idx] && !excl_i[idx]) begin
        if (!found_a) begin
          gnt_a_o[idx] = 1'b1;
          idx_a_o      = idx;
          addr_a       = addr_i[idx];
          found_a      = 1'b1;
        end else if (!found_b && addr_i[idx] != addr_a) begin
          gnt_b_o[idx] = 1'b1;
          idx_b_o      = idx;
          found_b      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Dual-port register-file writeback arbiter with optional producer scoreboard.
// Scoreboard (busy bitmap, hazard) is built only when RF_WB_SCOREBOARD_EN is defined.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int  EMBEDDED = 1,
  parameter int  NREQ     = 3,
  localparam int AW       = aw(EMBEDDED != 0)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NREQ-1:0]           req_valid_i,
  input  logic [NREQ*AW-1:0]        req_addr_i,
  input  logic [NREQ*RF_DATA_W-1:0] req_data_i,
  output logic [NREQ-1:0]           req_ready_o,
  output logic [AW-1:0]             wr1_addr_o,
  output logic [RF_DATA_W-1:0]      wr1_data_o,
  output logic [AW-1:0]             wr2_addr_o,
  output logic [RF_DATA_W-1:0]      wr2_data_o,
  input  logic                      alloc_valid_i,
  input  logic [AW-1:0]             alloc_addr_i,
  input  logic [AW-1:0]             chk_rs1_addr_i,
  input  logic [AW-1:0]             chk_rs2_addr_i,
  input  logic [AW-1:0]             chk_rd_addr_i,
  output logic                      hazard_o,
  output logic [(1<<AW)-1:0]        busy_o
);

  localparam int PW   = $clog2(NREQ);
  localparam int NREG = 1 << AW;

  wb_req_t              req [NREQ];
  logic [RF_AW_MAX-1:0] req_addr_w [NREQ];
  logic [NREQ-1:0]      nz, excl, gnt_a, gnt_b, sel1, sel2;
  logic [PW-1:0]        idx_a, idx_b, last_rr, ptr_q, ptr_d;
  logic                 g0;
  logic [AW-1:0]        wr1_addr_q, wr1_addr_d, wr2_addr_q, wr2_addr_d;
  logic [RF_DATA_W-1:0] wr1_data_q, wr1_data_d, wr2_data_q, wr2_data_d;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req[i].addr   = RF_AW_MAX'(req_addr_i[i*AW +: AW]);
      req[i].data   = req_data_i[i*RF_DATA_W +: RF_DATA_W];
      req_addr_w[i] = req[i].addr;
      nz[i]         = req_valid_i[i] && (req[i].addr != '0);
    end
  end

  // Requester 0 always wins the first slot; round-robin entries aimed at its address sit out.
  assign g0 = nz[0];

  always_comb begin
    excl    = '0;
    excl[0] = 1'b1;
    for (int i = 1; i < NREQ; i++) excl[i] = g0 && (req[i].addr == req[0].addr);
  end

  rf_wb_rr_pick #(.NREQ(NREQ), .AW(RF_AW_MAX)) u_pick (
    .cand_i  (nz),
    .excl_i  (excl),
    .ptr_i   (ptr_q),
    .addr_i  (req_addr_w),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b),
    .idx_a_o (idx_a),
    .idx_b_o (idx_b)
  );

  always_comb begin
    sel1    = g0 ? NREQ'(1) : gnt_a;
    sel2    = g0 ? gnt_a : gnt_b;
    last_rr = (!g0 && |gnt_b) ? idx_b : idx_a;
    ptr_d   = ptr_q;
    if (|gnt_a) ptr_d = (last_rr == PW'(NREQ-1)) ? PW'(1) : last_rr + 1'b1;
    wr1_addr_d = '0;
    wr1_data_d = '0;
    wr2_addr_d = '0;
    wr2_data_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel1[i]) begin
        wr1_addr_d = req[i].addr[AW-1:0];
        wr1_data_d = req[i].data;
      end
      if (sel2[i]) begin
        wr2_addr_d = req[i].addr[AW-1:0];
        wr2_data_d = req[i].data;
      end
    end
  end

  assign req_ready_o = sel1 | sel2 | (req_valid_i & ~nz);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= PW'(1);
      wr1_addr_q <= '0;
      wr1_data_q <= '0;
      wr2_addr_q <= '0;
      wr2_data_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wr1_addr_q <= wr1_addr_d;
      wr1_data_q <= wr1_data_d;
      wr2_addr_q <= wr2_addr_d;
      wr2_data_q <= wr2_data_d;
    end
  end

  assign wr1_addr_o = wr1_addr_q;
  assign wr1_data_o = wr1_data_q;
  assign wr2_addr_o = wr2_addr_q;
  assign wr2_data_o = wr2_data_q;

`ifdef RF_WB_SCOREBOARD_EN
  logic [NREG-1:0] busy_q, busy_d;

  // Clear from the port registers so busy drops on the edge the register file captures.
  always_comb begin
    busy_d             = busy_q;
    busy_d[wr1_addr_q] = 1'b0;
    busy_d[wr2_addr_q] = 1'b0;
    if (alloc_valid_i) busy_d[alloc_addr_i] = 1'b1;
    busy_d[0]          = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o   = busy_q;
  assign hazard_o = busy_q[chk_rs1_addr_i] | busy_q[chk_rs2_addr_i] | busy_q[chk_rd_addr_i];
`else
  logic unused_ok;
  assign unused_ok = ^{alloc_valid_i, alloc_addr_i, chk_rs1_addr_i, chk_rs2_addr_i, chk_rd_addr_i};
  assign busy_o    = {NREG{1'b0}};
  assign hazard_o  = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter (NREQ=4, AW=4); follows RF_WB_SCOREBOARD_EN.
module tb_rf_wb_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int NREG = 16;
`ifdef RF_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*32-1:0]   req_data;
  logic [AW-1:0]        wr1_addr, wr2_addr;
  logic [31:0]          wr1_data, wr2_data;
  logic                 alloc_valid;
  logic [AW-1:0]        alloc_addr, chk_rs1, chk_rs2, chk_rd;
  logic                 hazard;
  logic [NREG-1:0]      busy;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.EMBEDDED(1), .NREQ(NREQ)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_addr_i     (req_addr),
    .req_data_i     (req_data),
    .req_ready_o    (req_ready),
    .wr1_addr_o     (wr1_addr),
    .wr1_data_o     (wr1_data),
    .wr2_addr_o     (wr2_addr),
    .wr2_data_o     (wr2_data),
    .alloc_valid_i  (alloc_valid),
    .alloc_addr_i   (alloc_addr),
    .chk_rs1_addr_i (chk_rs1),
    .chk_rs2_addr_i (chk_rs2),
    .chk_rd_addr_i  (chk_rd),
    .hazard_o       (hazard),
    .busy_o         (busy)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } ent_t;
  typedef struct packed { logic [AW-1:0] a1; logic [31:0] d1; logic [AW-1:0] a2; logic [31:0] d2; } exp_t;

  ent_t            pend [NREQ][$];
  exp_t            exp_q[$];
  int              n_chk = 0, n_fail = 0;
  int              m_ptr;
  logic [NREG-1:0] m_busy;
  logic [AW-1:0]   m_p1, m_p2;
  logic [NREQ-1:0] last_rdy;
  int              gcount [NREQ];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int r, input int a, input logic [31:0] d);
    ent_t e;
    e.addr = AW'(a);
    e.data = d;
    pend[r].push_back(e);
  endtask

  task automatic present();
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_addr[i*AW +: AW]  = pend[i][0].addr;
        req_data[i*32 +: 32]  = pend[i][0].data;
      end else begin
        req_valid[i]          = 1'b0;
        req_addr[i*AW +: AW]  = '0;
        req_data[i*32 +: 32]  = '0;
      end
    end
  endtask

  // One clock: predict grants from the rank list, check, then check the ports after the edge.
  task automatic step();
    int              order[$];
    int              r, ng, last;
    logic [AW-1:0]   ga0;
    logic [NREQ-1:0] erdy;
    exp_t            e, got;
    ent_t            tmp;
    present();
    #1;
    order.push_back(0);
    for (int k = 0; k < NREQ-1; k++) order.push_back(1 + (m_ptr - 1 + k) % (NREQ-1));
    ng = 0; last = -1; erdy = '0; e = '0; ga0 = '0;
    foreach (order[j]) begin
      r = order[j];
      if (pend[r].size() > 0) begin
        if (pend[r][0].addr == '0) erdy[r] = 1'b1;
        else if (ng < 2 && !(ng == 1 && pend[r][0].addr == ga0)) begin
          erdy[r] = 1'b1;
          if (ng == 0) begin
            e.a1 = pend[r][0].addr; e.d1 = pend[r][0].data; ga0 = pend[r][0].addr;
          end else begin
            e.a2 = pend[r][0].addr; e.d2 = pend[r][0].data;
          end
          ng++;
          if (r != 0) last = r;
        end
      end
    end
    last_rdy = req_ready;
    check("ready", 64'(req_ready), 64'(erdy));
    check("hazard", 64'(hazard), 64'(SB && (m_busy[chk_rs1] || m_busy[chk_rs2] || m_busy[chk_rd])));
    check("busy", 64'(busy), SB ? 64'(m_busy) : 64'(0));
    exp_q.push_back(e);
    for (int i = 0; i < NREQ; i++)
      if (erdy[i]) begin
        if (pend[i][0].addr != '0) gcount[i]++;
        tmp = pend[i].pop_front();
      end
    @(posedge clk);
    m_busy[m_p1] = 1'b0;
    m_busy[m_p2] = 1'b0;
    if (alloc_valid) m_busy[alloc_addr] = 1'b1;
    m_busy[0] = 1'b0;
    m_p1 = e.a1;
    m_p2 = e.a2;
    if (last >= 0) m_ptr = (last == NREQ-1) ? 1 : last + 1;
    #1;
    got = exp_q.pop_front();
    check("wr1_addr", 64'(wr1_addr), 64'(got.a1));
    check("wr1_data", 64'(wr1_data), 64'(got.d1));
    check("wr2_addr", 64'(wr2_addr), 64'(got.a2));
    check("wr2_data", 64'(wr2_data), 64'(got.d2));
    check("dup_addr", 64'(wr1_addr != '0 && wr1_addr == wr2_addr), 64'(0));
  endtask

  task automatic model_reset();
    m_ptr = 1; m_busy = '0; m_p1 = '0; m_p2 = '0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) pend[i].delete();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    alloc_valid = 1'b0; alloc_addr = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    for (int i = 0; i < NREQ; i++) gcount[i] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_wr1_addr", 64'(wr1_addr), 64'(0));
    check("rst_wr2_addr", 64'(wr2_addr), 64'(0));
    check("rst_wr1_data", 64'(wr1_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_hazard", 64'(hazard), 64'(0));

    // Three writers at pointer 1: req 0 and 1 first, req 2 next cycle.
    push(0, 5, 32'hAAAA0001); push(1, 6, 32'hBBBB0006); push(2, 7, 32'hCCCC0007);
    step();
    check("t2_rdy", 64'(last_rdy), 64'b0011);
    check("t2_wr1", 64'({wr1_addr, wr1_data}), 64'({4'd5, 32'hAAAA0001}));
    check("t2_wr2", 64'(wr2_addr), 64'd6);
    step();
    check("t2_rdy2", 64'(last_rdy), 64'b0100);
    check("t2_wr1b", 64'(wr1_addr), 64'd7);
    step();

    // Same-address conflict on x9.
    push(0, 9, 32'h11); push(1, 9, 32'h22); push(2, 3, 32'h33);
    step();
    check("t3_rdy", 64'(last_rdy), 64'b0101);
    check("t3_ports", 64'({wr1_addr, wr2_addr}), 64'({4'd9, 4'd3}));
    step();
    check("t3_rdy2", 64'(last_rdy), 64'b0010);
    check("t3_wr1", 64'({wr1_addr, wr1_data}), 64'({4'd9, 32'h22}));

    // Requesters 1 and 2 streaming, then 1..3 for fairness.
    for (int n = 0; n < 6; n++) begin push(1, 10, 32'h100 + n); push(2, 11, 32'h200 + n); end
    for (int n = 0; n < 6; n++) begin
      step();
      check("t4_both", 64'(last_rdy), 64'b0110);
    end
    for (int i = 0; i < NREQ; i++) gcount[i] = 0;
    for (int n = 0; n < 10; n++) begin
      push(1, 10, 32'h1000 + n); push(2, 11, 32'h2000 + n); push(3, 12, 32'h3000 + n);
    end
    repeat (10) step();
    for (int i = 1; i < NREQ; i++) check("t4_fair", 64'(gcount[i] >= 6), 64'(1));
    for (int n = 0; n < 20 && (pend[1].size() + pend[2].size() + pend[3].size()) > 0; n++) step();
    check("t4_drained", 64'(pend[1].size() + pend[2].size() + pend[3].size()), 64'(0));

    // Scoreboard: alloc x4, write it, re-alloc while it is on a port.
    alloc_valid = 1'b1; alloc_addr = 4'd4;
    step();
    alloc_valid = 1'b0; chk_rs1 = 4'd4;
    check("t5_haz_set", 64'(hazard), 64'(SB));
    push(1, 4, 32'h44);
    step();
    check("t5_haz_n1", 64'(hazard), 64'(SB));
    chk_rs1 = 4'd0; alloc_valid = 1'b1; alloc_addr = 4'd4;
    step();
    alloc_valid = 1'b0;
    check("t5_setwins", 64'(busy[4]), 64'(SB));
    chk_rs1 = 4'd4;
    push(2, 4, 32'h45);
    step();
    step();
    check("t5_clear", 64'(busy[4]), 64'(0));
    check("t5_haz_n2", 64'(hazard), 64'(0));
    chk_rs1 = 4'd0;

    // x0 write consumes no port; then reset with a grant in flight.
    push(2, 0, 32'hDEAD);
    step();
    check("t6_x0_rdy", 64'(last_rdy), 64'b0100);
    check("t6_x0_port", 64'({wr1_addr, wr2_addr}), 64'(0));
    push(0, 8, 32'h88);
    alloc_valid = 1'b1; alloc_addr = 4'd2;
    step();
    alloc_valid = 1'b0;
    check("t6_inflight", 64'(wr1_addr), 64'd8);
    rst_n = 1'b0;
    #1;
    check("t6_rst_wr1", 64'({wr1_addr, wr1_data}), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    push(1, 1, 32'h1); push(2, 2, 32'h2); push(3, 3, 32'h3);
    step();
    check("t6_ptr_reset", 64'(last_rdy), 64'b0110);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
